rr_encoder8x3: RTL and testbench

Registered 8-to-3 round-robin encoder: the encoding counterpart of the 3-to-8 decoder. It takes up to eight request lines and produces one 3-bit index per grant, with a one-hot echo, through a valid/ready handshake. Rotating priority gives every requester a fair turn. It sits in front of the 8:1 multiplexer and decoder datapath and drives their select lines.

---
 rtl/rr_encoder8x3_pkg.sv | 12 +
 rtl/rr_encoder8x3_pick.sv | 31 +++
 rtl/rr_encoder8x3.sv | 87 ++++++++
 tb/tb_rr_encoder8x3.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rr_encoder8x3_pkg.sv
// Shared constants and state encoding for the round-robin 8-to-3 encoder.
package rr_encoder8x3_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_encoder8x3_pick.sv
// Combinational rotating-priority pick: first set request at or above ptr, wrapping.
module rr_pick
    import rr_encoder8x3_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic [0:0]         any_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    // Rotating the doubled vector puts req[ptr] at bit 0.
    assign dbl = {req_i, req_i} >> ptr_i;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign idx_o = ptr_i + off;
    assign any_o = |req_i;

endmodule

// File: rtl/rr_encoder8x3.sv
// Registered 8-to-3 round-robin encoder with sticky grant and valid/ready output.
module rr_encoder8x3
    import rr_encoder8x3_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [IDX_W-1:0]   code,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic               none
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   code_q, code_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               none_q, none_d;

    logic [IDX_W-1:0]   pick_idx;
    logic [0:0]         pick_any;

    rr_pick u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            code_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            none_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            none_q  <= none_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        code_d  = code_q;
        grant_d = grant_q;
        valid_d = valid_q;
        none_d  = none_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any[0]) begin
                    code_d  = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    valid_d = 1'b1;
                    none_d  = 1'b0;
                    state_d = ST_GRANT;
                end else begin
                    none_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                // Accept: advance priority past the winner; code is left as-is.
                if (out_ready) begin
                    ptr_d   = code_q + IDX_W'(1);
                    grant_d = '0;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = valid_q;
    assign code      = code_q;
    assign grant_oh  = grant_q;
    assign none      = none_q;

endmodule

// File: tb/tb_rr_encoder8x3.sv
// Directed self-checking bench for rr_encoder8x3.
module tb_rr_encoder8x3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] code;
    logic [7:0] grant_oh;
    logic       none;

    int n_checks;
    int n_fail;

    rr_encoder8x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .code      (code),
        .grant_oh  (grant_oh),
        .none      (none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] c,
                              input logic [7:0] g);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
        check_eq({tag, ".code"},  32'(code),      32'(c));
        check_eq({tag, ".grant"}, 32'(grant_oh),  32'(g));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] oh;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b0;

        // Reset held two cycles with all requests up.
        repeat (2) begin
            tick();
            expect_out("rst", 1'b0, 3'd0, 8'h00);
            check_eq("rst.none", 32'(none), 32'd1);
            check_eq("rst.ptr",  32'(dut.ptr_q), 32'd0);
        end

        // Fair rotation with req=FF and out_ready held high.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        expect_out("rot0", 1'b1, 3'd0, 8'h01);
        check_eq("rot0.none", 32'(none), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("rot.bubble", 32'(out_valid), 32'd0);
            check_eq("rot.bubble_oh", 32'(grant_oh), 32'd0);
            tick();
            oh = 8'h01 << (k % 8);
            expect_out("rot", 1'b1, 3'(k % 8), oh);
        end

        // Single request.
        do_reset();
        out_ready = 1'b0;
        req       = 8'h08;
        tick();
        expect_out("single", 1'b1, 3'd3, 8'h08);
        out_ready = 1'b1;
        req       = 8'h00;
        tick();
        expect_out("single.acc", 1'b0, 3'd3, 8'h00);
        check_eq("single.ptr", 32'(dut.ptr_q), 32'd4);
        tick();
        check_eq("single.none", 32'(none), 32'd1);
        check_eq("single.idle", 32'(out_valid), 32'd0);

        // Backpressure with sticky grant while req drops.
        do_reset();
        out_ready = 1'b0;
        req       = 8'h21;
        tick();
        expect_out("bp.first", 1'b1, 3'd0, 8'h01);
        req = 8'h00;
        repeat (5) begin
            tick();
            expect_out("bp.stall", 1'b1, 3'd0, 8'h01);
        end
        out_ready = 1'b1;
        tick();
        expect_out("bp.acc", 1'b0, 3'd0, 8'h00);
        req = 8'h21;
        tick();
        expect_out("bp.next", 1'b1, 3'd5, 8'h20);

        // Pointer wrap from 7 to 0.
        do_reset();
        out_ready = 1'b1;
        req       = 8'h40;
        tick();
        expect_out("wrap.g6", 1'b1, 3'd6, 8'h40);
        req = 8'h41;
        tick();
        check_eq("wrap.ptr7", 32'(dut.ptr_q), 32'd7);
        tick();
        expect_out("wrap.g0", 1'b1, 3'd0, 8'h01);
        tick();
        check_eq("wrap.ptr1", 32'(dut.ptr_q), 32'd1);
        tick();
        expect_out("wrap.g6b", 1'b1, 3'd6, 8'h40);

        // Reset lands on a pending grant with out_ready high.
        do_reset();
        out_ready = 1'b0;
        req       = 8'h20;
        tick();
        expect_out("mid.g5", 1'b1, 3'd5, 8'h20);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        tick();
        expect_out("mid.rst", 1'b0, 3'd0, 8'h00);
        check_eq("mid.ptr",  32'(dut.ptr_q), 32'd0);
        check_eq("mid.none", 32'(none), 32'd1);
        rst_n = 1'b1;
        req   = 8'h81;
        tick();
        expect_out("mid.after", 1'b1, 3'd0, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
